pwm_demod: RTL and testbench

//  Receive-side counterpart of the PWM DAC pair. Recovers one N-bit sample per PWM frame from the

---
 rtl/pwm_demod.sv | 169 ++++++++++++++++
 tb/tb_pwm_demod.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// PWM receiver: recovers one N-bit sample per 2^N-tick frame from the pwm_pos/pwm_neg pair.
// It counts the high ticks on each line and presents pos, neg and their signed difference on a
// valid/ready interface.
module pwm_demod #(
  parameter int unsigned N     = 8,
  parameter int unsigned DIV   = 125,
  parameter int unsigned DIV_W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_pos,
  input  logic         pwm_neg,
  output logic         s_valid,
  input  logic         s_ready,
  output logic [N-1:0] s_pos,
  output logic [N-1:0] s_neg,
  output logic [N:0]   s_diff,
  output logic         locked,
  output logic         overrun
);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  localparam logic [DIV_W-1:0] PrescLast = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] PrescMid  = DIV_W'(DIV / 2);
  localparam logic [N-1:0]     TickLast  = '1;

  state_e           state_q, state_d;
  logic             pos_meta_q, pos_meta_d, pos_sync_q, pos_sync_d, pos_prev_q, pos_prev_d;
  logic             neg_meta_q, neg_meta_d, neg_sync_q, neg_sync_d, neg_prev_q, neg_prev_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [N-1:0]     tick_ctr_q, tick_ctr_d;
  logic [N:0]       hi_pos_q, hi_pos_d, hi_neg_q, hi_neg_d;
  logic             s_valid_q, s_valid_d;
  logic [N-1:0]     s_pos_q, s_pos_d, s_neg_q, s_neg_d;
  logic [N:0]       s_diff_q, s_diff_d;
  logic             locked_q, locked_d, overrun_q, overrun_d;

  logic             any_rise, legal_edge, presc_wrap, at_mid, frame_end;
  logic [N:0]       hi_pos_acc, hi_neg_acc;
  logic [N-1:0]     pos_sat, neg_sat;

  assign any_rise   = (pos_sync_q & ~pos_prev_q) | (neg_sync_q & ~neg_prev_q);
  // Edges at the frame seam are the transmitter's normal frame starts.
  assign legal_edge = (tick_ctr_q == TickLast) || (tick_ctr_q == '0);
  assign presc_wrap = (presc_q == PrescLast);
  assign at_mid     = (presc_q == PrescMid);
  assign frame_end  = (state_q == StLocked) && (tick_ctr_q == TickLast) && presc_wrap;

  // Include the current mid-tick sample so a frame end never loses its last tick.
  assign hi_pos_acc = hi_pos_q + (N+1)'(pos_sync_q && at_mid);
  assign hi_neg_acc = hi_neg_q + (N+1)'(neg_sync_q && at_mid);
  assign pos_sat    = hi_pos_acc[N] ? '1 : hi_pos_acc[N-1:0];
  assign neg_sat    = hi_neg_acc[N] ? '1 : hi_neg_acc[N-1:0];

  always_comb begin
    pos_meta_d = pwm_pos;
    pos_sync_d = pos_meta_q;
    pos_prev_d = pos_sync_q;
    neg_meta_d = pwm_neg;
    neg_sync_d = neg_meta_q;
    neg_prev_d = neg_sync_q;
    state_d    = state_q;
    presc_d    = presc_q;
    tick_ctr_d = tick_ctr_q;
    hi_pos_d   = hi_pos_q;
    hi_neg_d   = hi_neg_q;
    s_valid_d  = s_valid_q;
    s_pos_d    = s_pos_q;
    s_neg_d    = s_neg_q;
    s_diff_d   = s_diff_q;
    locked_d   = locked_q;
    overrun_d  = overrun_q;

    if (s_valid_q && s_ready) begin
      s_valid_d = 1'b0;
    end

    unique case (state_q)
      StSearch: begin
        if (any_rise) begin
          state_d    = StLocked;
          presc_d    = '0;
          tick_ctr_d = '0;
          hi_pos_d   = '0;
          hi_neg_d   = '0;
        end
      end
      StLocked: begin
        if (any_rise && !legal_edge) begin
          // Misaligned edge: restart the frame here, held sample stays untouched.
          presc_d    = '0;
          tick_ctr_d = '0;
          hi_pos_d   = '0;
          hi_neg_d   = '0;
          locked_d   = 1'b0;
        end else begin
          presc_d  = presc_wrap ? '0 : presc_q + DIV_W'(1);
          hi_pos_d = hi_pos_acc;
          hi_neg_d = hi_neg_acc;
          if (presc_wrap) begin
            tick_ctr_d = tick_ctr_q + N'(1);
          end
          if (frame_end) begin
            s_pos_d   = pos_sat;
            s_neg_d   = neg_sat;
            s_diff_d  = {1'b0, pos_sat} - {1'b0, neg_sat};
            s_valid_d = 1'b1;
            locked_d  = 1'b1;
            hi_pos_d  = '0;
            hi_neg_d  = '0;
            if (s_valid_q && !s_ready) begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StSearch;
      pos_meta_q <= 1'b0;
      pos_sync_q <= 1'b0;
      pos_prev_q <= 1'b0;
      neg_meta_q <= 1'b0;
      neg_sync_q <= 1'b0;
      neg_prev_q <= 1'b0;
      presc_q    <= '0;
      tick_ctr_q <= '0;
      hi_pos_q   <= '0;
      hi_neg_q   <= '0;
      s_valid_q  <= 1'b0;
      s_pos_q    <= '0;
      s_neg_q    <= '0;
      s_diff_q   <= '0;
      locked_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_meta_q <= pos_meta_d;
      pos_sync_q <= pos_sync_d;
      pos_prev_q <= pos_prev_d;
      neg_meta_q <= neg_meta_d;
      neg_sync_q <= neg_sync_d;
      neg_prev_q <= neg_prev_d;
      presc_q    <= presc_d;
      tick_ctr_q <= tick_ctr_d;
      hi_pos_q   <= hi_pos_d;
      hi_neg_q   <= hi_neg_d;
      s_valid_q  <= s_valid_d;
      s_pos_q    <= s_pos_d;
      s_neg_q    <= s_neg_d;
      s_diff_q   <= s_diff_d;
      locked_q   <= locked_d;
      overrun_q  <= overrun_d;
    end
  end

  assign s_valid = s_valid_q;
  assign s_pos   = s_pos_q;
  assign s_neg   = s_neg_q;
  assign s_diff  = s_diff_q;
  assign locked  = locked_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod with a short frame (N=4, DIV=5 -> 80 clk per frame).
// A frame-accurate PWM source drives the lines; accepted samples are checked against a queue.
module tb_pwm_demod;

  localparam int N        = 4;
  localparam int Div      = 5;
  localparam int DivW     = 3;
  localparam int FrameCyc = (1 << N) * Div;
  localparam int MaxCnt   = (1 << N) - 1;

  typedef struct packed {
    logic [N-1:0] p;
    logic [N-1:0] n;
    logic [N:0]   d;
  } sample_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         pwm_pos, pwm_neg;
  logic         s_valid, s_ready;
  logic [N-1:0] s_pos, s_neg;
  logic [N:0]   s_diff;
  logic         locked, overrun;

  int      n_checks = 0;
  int      n_fail   = 0;
  sample_t exp_q[$];
  sample_t mon_e;

  pwm_demod #(
    .N    (N),
    .DIV  (Div),
    .DIV_W(DivW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pwm_pos(pwm_pos),
    .pwm_neg(pwm_neg),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_pos  (s_pos),
    .s_neg  (s_neg),
    .s_diff (s_diff),
    .locked (locked),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input int p_on, input int n_on);
    sample_t s;
    int      sp, sn;
    sp  = (p_on > MaxCnt) ? MaxCnt : p_on;
    sn  = (n_on > MaxCnt) ? MaxCnt : n_on;
    s.p = sp[N-1:0];
    s.n = sn[N-1:0];
    s.d = (N+1)'(sp - sn);
    exp_q.push_back(s);
  endtask

  // Drive frame cycles [c0, c1); each line is high for its first *_on ticks.
  task automatic run_cyc(input int p_on, input int n_on, input int c0, input int c1);
    for (int c = c0; c < c1; c++) begin
      pwm_pos = ((c / Div) < p_on);
      pwm_neg = ((c / Div) < n_on);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int p_on, input int n_on, input bit expect_sample);
    if (expect_sample) exp_push(p_on, n_on);
    run_cyc(p_on, n_on, 0, FrameCyc);
  endtask

  always @(negedge clk) begin
    if (!reset && s_valid && s_ready) begin
      check_eq("sample_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("s_pos", 32'(s_pos), 32'(mon_e.p));
        check_eq("s_neg", 32'(s_neg), 32'(mon_e.n));
        check_eq("s_diff", 32'(s_diff), 32'(mon_e.d));
      end
    end
  end

  initial begin
    reset   = 1'b1;
    pwm_pos = 1'b0;
    pwm_neg = 1'b0;
    s_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_valid", 32'(s_valid), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_pos", 32'(s_pos), 32'd0);
    check_eq("rst_diff", 32'(s_diff), 32'd0);
    run_cyc(0, 0, 0, 20);
    check_eq("search_locked", 32'(locked), 32'd0);
    check_eq("search_valid", 32'(s_valid), 32'd0);

    // Steady positive, then negative, then mixed levels.
    run_frame(10, 0, 1'b1);
    run_frame(10, 0, 1'b1);
    check_eq("t1_locked", 32'(locked), 32'd1);
    run_frame(10, 0, 1'b1);
    run_frame(0, 7, 1'b1);
    run_frame(0, 7, 1'b1);
    run_frame(12, 5, 1'b1);
    run_frame(3, 9, 1'b1);

    // Full scale, always-high saturation, idle lines.
    run_frame(15, 0, 1'b1);
    run_frame(16, 0, 1'b1);
    run_frame(0, 0, 1'b1);
    run_frame(0, 0, 1'b1);
    check_eq("t3_idle_locked", 32'(locked), 32'd1);

    // Back-pressure: frames 2 and 4 are overwritten, 6 is held, then 8 loads as 6 is taken.
    run_cyc(2, 0, 0, 5);
    s_ready = 1'b0;
    run_cyc(2, 0, 5, FrameCyc);
    run_frame(4, 0, 1'b0);
    check_eq("t4_valid_held", 32'(s_valid), 32'd1);
    check_eq("t4_no_overrun", 32'(overrun), 32'd0);
    check_eq("t4_pos_held", 32'(s_pos), 32'd2);
    run_frame(6, 0, 1'b1);
    check_eq("t4_overrun", 32'(overrun), 32'd1);
    check_eq("t4_pos_over", 32'(s_pos), 32'd4);
    run_frame(8, 0, 1'b1);
    check_eq("t4_pos_last", 32'(s_pos), 32'd6);
    check_eq("t4_valid_last", 32'(s_valid), 32'd1);
    exp_push(0, 0);
    run_cyc(0, 0, 0, 2);
    s_ready = 1'b1;
    run_cyc(0, 0, 2, 3);
    check_eq("t4_valid_kept", 32'(s_valid), 32'd1);
    check_eq("t4_pos_new", 32'(s_pos), 32'd8);
    run_cyc(0, 0, 3, FrameCyc);
    check_eq("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Misaligned edge at tick 8 drops the partial frame.
    run_frame(5, 0, 1'b1);
    run_cyc(5, 0, 0, 8 * Div);
    run_frame(7, 0, 1'b1);
    check_eq("t5_unlocked", 32'(locked), 32'd0);
    check_eq("t5_no_valid", 32'(s_valid), 32'd0);
    run_frame(7, 0, 1'b1);
    check_eq("t5_relocked", 32'(locked), 32'd1);

    // One-cycle reset mid-frame, then relock.
    run_frame(3, 0, 1'b1);
    run_cyc(3, 0, 0, 30);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("t6_valid", 32'(s_valid), 32'd0);
    check_eq("t6_locked", 32'(locked), 32'd0);
    check_eq("t6_overrun", 32'(overrun), 32'd0);
    check_eq("t6_pos", 32'(s_pos), 32'd0);
    check_eq("t6_neg", 32'(s_neg), 32'd0);
    check_eq("t6_diff", 32'(s_diff), 32'd0);
    run_cyc(0, 0, 0, 20);
    check_eq("t6_search", 32'(locked), 32'd0);
    run_frame(9, 0, 1'b1);
    run_frame(4, 4, 1'b1);
    run_cyc(0, 0, 0, 10);
    check_eq("t6_relocked", 32'(locked), 32'd1);
    check_eq("all_samples_seen", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
